// File: rtl/mux_nw_scan_reg.sv
// Registered N:1 selector for W-bit channels with manual select and timed auto-scan.
// Out-of-range manual selects raise err and leave y/ch at their previous values.
module mux_nw_scan_lane #(
  parameter int W    = 2,
  parameter int SELW = 2,
  parameter int IDX  = 0
) (
  input  logic [SELW-1:0] idx,
  input  logic [W-1:0]    din,
  output logic [W-1:0]    dout
);
  assign dout = (idx == SELW'(IDX)) ? din : '0;
endmodule

module mux_nw_scan_reg #(
  parameter  int N    = 3,
  parameter  int W    = 2,
  parameter  int DIV  = 4,
  localparam int SELW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*W-1:0]  d,
  input  logic [SELW-1:0] sel,
  input  logic            scan,
  input  logic            hold,
  output logic [W-1:0]    y,
  output logic [SELW-1:0] ch,
  output logic            err
);
  localparam int CW = $clog2(DIV) + 1;
  localparam logic [SELW:0] NCH = (SELW+1)'(N);

  logic [SELW-1:0]       ptr;
  logic [CW-1:0]         cnt;
  logic [SELW-1:0]       idx;
  logic                  sel_ok;
  logic [N-1:0][W-1:0]   lane_q;
  logic [W-1:0]          mux_q;

  assign idx    = scan ? ptr : sel;
  assign sel_ok = {1'b0, sel} < NCH;

  // One-hot AND-OR mux: each lane gates its own channel, unmatched lanes give 0.
  for (genvar i = 0; i < N; i++) begin : g_lane
    mux_nw_scan_lane #(.W(W), .SELW(SELW), .IDX(i)) u_lane (
      .idx  (idx),
      .din  (d[i*W +: W]),
      .dout (lane_q[i])
    );
  end

  always_comb begin
    mux_q = '0;
    for (int i = 0; i < N; i++) mux_q = mux_q | lane_q[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y   <= '0;
      ch  <= '0;
      err <= 1'b0;
      ptr <= '0;
      cnt <= '0;
    end else if (!hold) begin
      if (scan) begin
        y   <= mux_q;
        ch  <= ptr;
        err <= 1'b0;
        if (cnt == CW'(DIV - 1)) begin
          cnt <= '0;
          // Wrap at N so unused pointer codes are never visited.
          ptr <= (ptr == SELW'(N - 1)) ? '0 : ptr + SELW'(1);
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
        if (sel_ok) begin
          y   <= mux_q;
          ch  <= sel;
          err <= 1'b0;
          ptr <= sel;
        end else begin
          err <= 1'b1;
          ptr <= ch;
        end
      end
    end
  end
endmodule

// File: tb/tb_mux_nw_scan_reg.sv
// Scoreboard bench: driver pushes model expectations, monitor pops and compares after each edge.
module tb_mux_nw_scan_reg;
  localparam int N    = 3;
  localparam int W    = 2;
  localparam int DIV  = 4;
  localparam int SELW = (N > 1) ? $clog2(N) : 1;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N*W-1:0]  d = '0;
  logic [SELW-1:0] sel = '0;
  logic            scan = 1'b0;
  logic            hold = 1'b0;
  logic [W-1:0]    y;
  logic [SELW-1:0] ch;
  logic            err;

  mux_nw_scan_reg #(.N(N), .W(W), .DIV(DIV)) dut (
    .clk(clk), .rst(rst), .d(d), .sel(sel), .scan(scan), .hold(hold),
    .y(y), .ch(ch), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]    y;
    logic [SELW-1:0] ch;
    logic            err;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference state: what is shown, and where the scan is and how long it has dwelt there.
  int m_y = 0, m_ch = 0, m_err = 0;
  int scan_ch = 0, scan_age = 0;

  function automatic int chan(input logic [N*W-1:0] dd, input int c);
    return int'(dd[c*W +: W]);
  endfunction

  task automatic step(input logic r, input logic h, input logic s,
                      input int sl, input logic [N*W-1:0] dd);
    exp_t e;
    @(negedge clk);
    rst = r; hold = h; scan = s; sel = SELW'(sl); d = dd;
    if (r) begin
      m_y = 0; m_ch = 0; m_err = 0; scan_ch = 0; scan_age = 0;
    end else if (!h) begin
      if (s) begin
        m_y = chan(dd, scan_ch); m_ch = scan_ch; m_err = 0;
        scan_age++;
        if (scan_age == DIV) begin
          scan_age = 0;
          scan_ch  = (scan_ch + 1) % N;
        end
      end else begin
        if (sl < N) begin
          m_y = chan(dd, sl); m_ch = sl; m_err = 0;
        end else begin
          m_err = 1;
        end
        scan_ch = m_ch; scan_age = 0;
      end
    end
    e.y = W'(m_y); e.ch = SELW'(m_ch); e.err = m_err[0];
    q.push_back(e);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        vectors++;
        if (y !== e.y || ch !== e.ch || err !== e.err || int'(ch) >= N) begin
          miscompares++;
          $display("FAIL out t=%0t got y=%b ch=%0d err=%b want y=%b ch=%0d err=%b",
                   $time, y, ch, err, e.y, e.ch, e.err);
        end
      end
    end
  end

  localparam logic [N*W-1:0] DV = 6'b11_10_01;
  localparam logic [N*W-1:0] DX = 6'b11_00_01;

  initial begin
    // reset with scan requested and all-ones data
    step(1, 0, 1, 0, '1);
    step(1, 0, 1, 0, '1);
    // manual select
    step(0, 0, 0, 0, DV);
    step(0, 0, 0, 1, DV);
    step(0, 0, 0, 2, DV);
    // out of range, d1 changes while sel is invalid
    step(0, 0, 0, 1, DV);
    step(0, 0, 0, 3, DV);
    step(0, 0, 0, 3, DX);
    step(0, 0, 0, 3, DX);
    step(0, 0, 0, 0, DV);
    // scan from ch1 with wrap
    step(0, 0, 0, 1, DV);
    for (int i = 0; i < 13; i++) step(0, 0, 1, 3, DV);
    // hold mid-dwell on ch2
    step(0, 0, 0, 1, DV);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 0, DV);
    for (int i = 0; i < 5; i++) step(0, 1, 1, 0, DX);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, DV);
    // reset together with hold and scan
    step(0, 0, 1, 0, DV);
    step(1, 1, 1, 0, DV);
    for (int i = 0; i < 9; i++) step(0, 0, 1, 0, DV);
    // randomized traffic; scan mode is sticky so dwell periods complete
    begin
      logic s = 1'b0;
      for (int i = 0; i < 2000; i++) begin
        if ($urandom_range(0, 15) == 0) s = ~s;
        step(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0), s,
             int'($urandom_range(0, (1 << SELW) - 1)), N*W'($urandom));
      end
    end
    repeat (3) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
